alu_cond_flags_stage: RTL and testbench

- Execute-stage companion to the ARMv4 ALU; holds the architectural C,N,V,Z flag register.
- Drives the flags back into the ALU's CNVZI input.
- Evaluates each instruction's 4-bit condition field against the committed flags.
- Commits ALU flag outputs (CNVZO) under S-bit/opcode rules, and registers the ALU result into the EX/MEM pipeline boundary with stall and flush support.

---
 rtl/alu_cond_flags_stage.sv | 134 +++++++++++++
 tb/tb_alu_cond_flags_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_cond_flags_stage.sv
// Execute-stage flag register and condition evaluator for the ARMv4 ALU.
// Commits CNVZ under S-bit/opcode rules and registers the ALU result into EX/MEM.
module alu_cond_flags_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned RW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [3:0]       cond_i,
   input  logic             s_bit_i,
   input  logic [3:0]       alufun_i,
   input  logic [3:0]       alu_flags_i,
   input  logic             sh_c_valid_i,
   input  logic             sh_c_i,
   input  logic [WIDTH-1:0] result_i,
   input  logic [RW-1:0]    rd_i,
   output logic [3:0]       cnvz_o,
   output logic             cond_pass_o,
   output logic             valid_o,
   output logic             reg_we_o,
   output logic [WIDTH-1:0] result_o,
   output logic [RW-1:0]    rd_o
);

   localparam int unsigned FC = 3;
   localparam int unsigned FN = 2;
   localparam int unsigned FV = 1;
   localparam int unsigned FZ = 0;

   logic [3:0]       cnvz_q,   cnvz_d;
   logic             valid_q,  valid_d;
   logic             reg_we_q, reg_we_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [RW-1:0]    rd_q,     rd_d;

   logic cond_true;
   logic exec;
   logic set_flags;
   logic arith_op;
   logic no_writeback;

   // Condition field evaluated against the committed flags.
   always_comb begin
      cond_true = 1'b0;
      case (cond_i)
         4'b0000: cond_true = cnvz_q[FZ];
         4'b0001: cond_true = ~cnvz_q[FZ];
         4'b0010: cond_true = cnvz_q[FC];
         4'b0011: cond_true = ~cnvz_q[FC];
         4'b0100: cond_true = cnvz_q[FN];
         4'b0101: cond_true = ~cnvz_q[FN];
         4'b0110: cond_true = cnvz_q[FV];
         4'b0111: cond_true = ~cnvz_q[FV];
         4'b1000: cond_true = cnvz_q[FC] & ~cnvz_q[FZ];
         4'b1001: cond_true = ~cnvz_q[FC] | cnvz_q[FZ];
         4'b1010: cond_true = (cnvz_q[FN] == cnvz_q[FV]);
         4'b1011: cond_true = (cnvz_q[FN] != cnvz_q[FV]);
         4'b1100: cond_true = ~cnvz_q[FZ] & (cnvz_q[FN] == cnvz_q[FV]);
         4'b1101: cond_true = cnvz_q[FZ] | (cnvz_q[FN] != cnvz_q[FV]);
         4'b1110: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   // Opcode classes: TST/TEQ/CMP/CMN always set flags and never write back.
   always_comb begin
      no_writeback = (alufun_i[3:2] == 2'b10);
      set_flags    = s_bit_i | no_writeback;
      arith_op     = (alufun_i[3:1] == 3'b001) | (alufun_i[3:2] == 2'b01)
                   | (alufun_i[3:1] == 3'b101);
      exec         = valid_i & cond_true & ~flush_i & ~stall_i;
   end

   // Flag commit: logical ops keep V and take C from the shifter only when it produced one.
   always_comb begin
      cnvz_d = cnvz_q;
      if (exec && set_flags) begin
         if (arith_op) begin
            cnvz_d = alu_flags_i;
         end else begin
            cnvz_d[FN] = alu_flags_i[FN];
            cnvz_d[FZ] = alu_flags_i[FZ];
            cnvz_d[FV] = cnvz_q[FV];
            cnvz_d[FC] = sh_c_valid_i ? sh_c_i : cnvz_q[FC];
         end
      end
   end

   // EX/MEM boundary: flush beats stall; idle slots only clear the valid bits.
   always_comb begin
      valid_d  = valid_q;
      reg_we_d = reg_we_q;
      result_d = result_q;
      rd_d     = rd_q;
      if (flush_i) begin
         valid_d  = 1'b0;
         reg_we_d = 1'b0;
      end else if (!stall_i) begin
         valid_d  = exec;
         reg_we_d = exec & ~no_writeback;
         if (valid_i) begin
            result_d = result_i;
            rd_d     = rd_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnvz_q   <= 4'b0000;
         valid_q  <= 1'b0;
         reg_we_q <= 1'b0;
         result_q <= WIDTH'(0);
         rd_q     <= RW'(0);
      end else begin
         cnvz_q   <= cnvz_d;
         valid_q  <= valid_d;
         reg_we_q <= reg_we_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   assign cnvz_o      = cnvz_q;
   assign cond_pass_o = valid_i & cond_true;
   assign valid_o     = valid_q;
   assign reg_we_o    = reg_we_q;
   assign result_o    = result_q;
   assign rd_o        = rd_q;

endmodule

// File: tb/tb_alu_cond_flags_stage.sv
// Directed plus random stimulus for alu_cond_flags_stage, checked against a reference model via a scoreboard queue.
module tb_alu_cond_flags_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i, stall_i, flush_i, s_bit_i, sh_c_valid_i, sh_c_i;
   logic [3:0]  cond_i, alufun_i, alu_flags_i, rd_i;
   logic [31:0] result_i;
   logic [3:0]  cnvz_o, rd_o;
   logic        cond_pass_o, valid_o, reg_we_o;
   logic [31:0] result_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0]  flags;
      logic        valid;
      logic        we;
      logic [31:0] res;
      logic [3:0]  rd;
   } exp_t;

   exp_t sb[$];

   logic [3:0]  m_flags;
   logic        m_valid, m_we;
   logic [31:0] m_res;
   logic [3:0]  m_rd;

   always #5 clk = ~clk;

   alu_cond_flags_stage #(.WIDTH(32), .RW(4)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
      .cond_i(cond_i), .s_bit_i(s_bit_i), .alufun_i(alufun_i), .alu_flags_i(alu_flags_i),
      .sh_c_valid_i(sh_c_valid_i), .sh_c_i(sh_c_i), .result_i(result_i), .rd_i(rd_i),
      .cnvz_o(cnvz_o), .cond_pass_o(cond_pass_o), .valid_o(valid_o), .reg_we_o(reg_we_o),
      .result_o(result_o), .rd_o(rd_o)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ARM reference: even codes give the base test, odd codes its inverse.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic fc, fn, fv, fz, base;
      {fc, fn, fv, fz} = f;
      case (c[3:1])
         3'd0: base = fz;
         3'd1: base = fc;
         3'd2: base = fn;
         3'd3: base = fv;
         3'd4: base = fc & !fz;
         3'd5: base = (fn == fv);
         3'd6: base = !fz & (fn == fv);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic step(input logic rst, input logic v, input logic st, input logic fl,
                       input logic [3:0] cond, input logic s, input logic [3:0] fun,
                       input logic [3:0] af, input logic shv, input logic shc,
                       input logic [31:0] res, input logic [3:0] rd);
      logic pass, ex, setf, arith;
      exp_t e, got;
      @(negedge clk);
      reset = rst; valid_i = v; stall_i = st; flush_i = fl; cond_i = cond; s_bit_i = s;
      alufun_i = fun; alu_flags_i = af; sh_c_valid_i = shv; sh_c_i = shc;
      result_i = res; rd_i = rd;
      #1;
      pass = v & cond_ok(cond, m_flags);
      chk("cond_pass", 32'(cond_pass_o), 32'(pass));
      ex    = pass & !fl & !st;
      setf  = s | (fun inside {4'd8, 4'd9, 4'd10, 4'd11});
      arith = fun inside {[4'd2:4'd7], 4'd10, 4'd11};
      if (rst) begin
         m_flags = 4'b0; m_valid = 1'b0; m_we = 1'b0; m_res = 32'b0; m_rd = 4'b0;
      end else begin
         if (ex && setf)
            m_flags = arith ? af : {shv ? shc : m_flags[3], af[2], m_flags[1], af[0]};
         if (fl) begin
            m_valid = 1'b0; m_we = 1'b0;
         end else if (!st) begin
            m_valid = ex;
            m_we    = ex & !(fun inside {[4'd8:4'd11]});
            if (v) begin m_res = res; m_rd = rd; end
         end
      end
      e = '{flags: m_flags, valid: m_valid, we: m_we, res: m_res, rd: m_rd};
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("cnvz", 32'(cnvz_o), 32'(got.flags));
      chk("valid_o", 32'(valid_o), 32'(got.valid));
      chk("reg_we_o", 32'(reg_we_o), 32'(got.we));
      if (got.valid) begin
         chk("result_o", result_o, got.res);
         chk("rd_o", 32'(rd_o), 32'(got.rd));
      end
   endtask

   initial begin
      m_flags = 4'b0; m_valid = 1'b0; m_we = 1'b0; m_res = 32'b0; m_rd = 4'b0;
      // Reset held two cycles with an executable flag-setting op present.
      step(1, 1, 0, 0, 4'hE, 1, 4'h2, 4'hF, 0, 0, 32'hDEAD, 4'd7);
      step(1, 1, 0, 0, 4'hE, 1, 4'h2, 4'hF, 0, 0, 32'hDEAD, 4'd7);
      chk("reset_cnvz", 32'(cnvz_o), 32'h0);
      chk("reset_result", result_o, 32'h0);
      // SUB sets Z, then NE fails.
      step(0, 1, 0, 0, 4'hE, 1, 4'h2, 4'b0001, 0, 0, 32'h0, 4'd3);
      chk("sub_flags", 32'(cnvz_o), 32'h1);
      chk("sub_rd", 32'(rd_o), 32'd3);
      step(0, 1, 0, 0, 4'h1, 1, 4'h4, 4'b1111, 0, 0, 32'h55, 4'd4);
      chk("ne_bubble", 32'(valid_o), 32'h0);
      // Logical op preserves V, C held or from shifter.
      step(0, 1, 0, 0, 4'hE, 1, 4'h4, 4'b1010, 0, 0, 32'h11, 4'd5);
      step(0, 1, 0, 0, 4'hE, 1, 4'h0, 4'b0100, 0, 0, 32'h22, 4'd6);
      chk("and_keep_c", 32'(cnvz_o), 32'hE);
      step(0, 1, 0, 0, 4'hE, 1, 4'h4, 4'b1010, 0, 0, 32'h33, 4'd5);
      step(0, 1, 0, 0, 4'hE, 1, 4'h0, 4'b0100, 1, 0, 32'h44, 4'd6);
      chk("and_shift_c", 32'(cnvz_o), 32'h6);
      // CMP without S still sets flags, no writeback; HI then fails.
      step(0, 1, 0, 0, 4'hE, 0, 4'hA, 4'b1001, 0, 0, 32'h66, 4'd8);
      chk("cmp_flags", 32'(cnvz_o), 32'h9);
      chk("cmp_no_we", 32'(reg_we_o), 32'h0);
      step(0, 1, 0, 0, 4'h8, 1, 4'h4, 4'b0000, 0, 0, 32'h77, 4'd9);
      // Stall holds everything; flush with stall clears valid.
      step(0, 1, 0, 0, 4'hE, 0, 4'hD, 4'b0000, 0, 0, 32'h88, 4'd10);
      repeat (3) step(0, 1, 1, 0, 4'hE, 1, 4'h4, 4'b0100, 0, 0, 32'h99, 4'd11);
      chk("stall_hold_rd", 32'(rd_o), 32'd10);
      step(0, 1, 1, 1, 4'hE, 1, 4'h4, 4'b0100, 0, 0, 32'hAA, 4'd12);
      chk("flush_flags", 32'(cnvz_o), 32'h9);
      // GE true with N=V=1; NV never passes nor writes.
      step(0, 1, 0, 0, 4'hE, 1, 4'h4, 4'b0110, 0, 0, 32'hBB, 4'd1);
      step(0, 1, 0, 0, 4'hA, 0, 4'hD, 4'b0000, 0, 0, 32'hCC, 4'd2);
      step(0, 1, 0, 0, 4'hF, 1, 4'h4, 4'b1001, 1, 1, 32'hDD, 4'd2);
      chk("nv_no_write", 32'(cnvz_o), 32'h6);
      // Random traffic with sparse reset, stall and flush.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
              4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), 1'($urandom), $urandom, 4'($urandom));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
